// File: rtl/mergesort_pkg.sv
// mergesort_pkg
//  Shared types and constants for the merge-sort accelerator.
//  - N, ELEM_W, PASSES  : array geometry (16 signed 16-bit elements, log2(16) passes)
//  - ADDR_W/DATA_W/SIZE_W : per-channel slave port field widths
//  - state_t            : top-level FSM states
//  - INIT_TABLE         : contents loaded into array A on reset
package mergesort_pkg;

  localparam int N        = 16;
  localparam int ELEM_W   = 16;
  localparam int PASSES   = 4;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int SIZE_W   = 4;
  localparam int CHANNELS = 2;

  typedef logic signed [ELEM_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  localparam elem_t INIT_TABLE [N] = '{
    16'sd11,  -16'sd3,   16'sd7,   16'sd0,
    16'sd250, -16'sd128, 16'sd42,  16'sd5,
    16'sd5,   -16'sd1,   16'sd99,  16'sd13,
    -16'sd77, 16'sd8,    16'sd1000, 16'sd2
  };

endpackage

// File: rtl/merge_select.sv
// merge_select
//  Combinational merge decision: picks the next element from the heads of
//  the left and right runs.
//  Ports:
//    left_head, right_head  in   current head element of each run
//    left_done, right_done  in   run has no elements left
//    take_left              out  1 = consume the left head
//    sel                    out  element written this cycle
//  Configuration: MERGESORT_DESC_EN selects descending order. In both orders
//  a tie takes the left run first, which keeps the sort stable.
module merge_select
  import mergesort_pkg::*;
(
  input  logic signed [ELEM_W-1:0] left_head,
  input  logic signed [ELEM_W-1:0] right_head,
  input  logic                     left_done,
  input  logic                     right_done,
  output logic                     take_left,
  output logic signed [ELEM_W-1:0] sel
);

  always_comb begin
    take_left = 1'b0;
    if (left_done) begin
      take_left = 1'b0;
    end else if (right_done) begin
      take_left = 1'b1;
    end else begin
`ifdef MERGESORT_DESC_EN
      take_left = (left_head >= right_head);
`else
      take_left = (left_head <= right_head);
`endif
    end
    sel = take_left ? left_head : right_head;
  end

endmodule

// File: rtl/mergesort_accel.sv
// mergesort_accel
//  Bottom-up merge sort of a 16-entry signed 16-bit array A, using B as a
//  ping-pong buffer. One merged element is written per cycle, four passes of
//  16 writes each, so the sorted data lands back in A after 64 SORT cycles.
//  Ports:
//    clock, reset (async, active-low)
//    start_port       in   start request, honoured only in IDLE
//    S_oe_ram/S_we_ram in  per-channel read/write enables (2 channels)
//    S_addr_ram       in   7-bit byte address per channel
//    S_Wdata_ram      in   write byte per channel
//    S_data_ram_size  in   access size in bits per channel (only 8 is served)
//    done_port        out  one-cycle pulse when the sort has finished
//    Sout_Rdata_ram   out  read byte per channel, registered
//    Sout_DataRdy     out  per-channel acknowledge, registered
//  Configuration: define MERGESORT_DESC_EN for a descending sort.
module mergesort_accel
  import mergesort_pkg::*;
#(
  parameter int MEM_var_28859_28863 = 64,
  parameter int MEM_var_28861_28867 = 32,
  parameter int MEM_var_29024_28863 = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start_port,
  input  logic [CHANNELS-1:0]            S_oe_ram,
  input  logic [CHANNELS-1:0]            S_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]     S_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]     S_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]     S_data_ram_size,
  output logic                           done_port,
  output logic [CHANNELS*DATA_W-1:0]     Sout_Rdata_ram,
  output logic [CHANNELS-1:0]            Sout_DataRdy
);

  // B is reachable through an alias base; the two must describe one region.
  if (MEM_var_29024_28863 != MEM_var_28861_28867) begin : g_alias_check
    $error("mergesort_accel: B alias base must equal B base");
  end

  localparam logic [7:0] A_BASE = 8'(MEM_var_28859_28863);
  localparam logic [7:0] B_BASE = 8'(MEM_var_28861_28867);
  localparam logic [7:0] SPAN   = 8'(2 * N);

  state_t state, next_state;

  elem_t mem_a [N];
  elem_t mem_b [N];

  logic [1:0]       pass;
  logic [IDX_W-1:0] blk_base, li, ri;
  logic [IDX_W-1:0] run_w, blk_mask, out_idx, l_idx, r_idx;
  elem_t            left_head, right_head, sel;
  logic             take_left, left_done, right_done, blk_last, sort_last;

  // Merge bookkeeping: a block of 2*run_w outputs starts at blk_base, li/ri
  // count elements already taken from the left/right run. Odd passes read B
  // and write A, even passes read A and write B.
  always_comb begin
    run_w    = 4'd1 << pass;
    blk_mask = 4'd1;
    case (pass)
      2'd0:    blk_mask = 4'd1;
      2'd1:    blk_mask = 4'd3;
      2'd2:    blk_mask = 4'd7;
      default: blk_mask = 4'd15;
    endcase
    out_idx    = blk_base + li + ri;
    l_idx      = blk_base + li;
    r_idx      = blk_base + run_w + ri;
    left_done  = (li == run_w);
    right_done = (ri == run_w);
    left_head  = pass[0] ? mem_b[l_idx] : mem_a[l_idx];
    right_head = pass[0] ? mem_b[r_idx] : mem_a[r_idx];
    blk_last   = ((out_idx & blk_mask) == blk_mask);
    sort_last  = (state == SORT) && (pass == 2'(PASSES - 1)) &&
                 (out_idx == 4'(N - 1));
  end

  merge_select u_merge_select (
    .left_head  (left_head),
    .right_head (right_head),
    .left_done  (left_done),
    .right_done (right_done),
    .take_left  (take_left),
    .sel        (sel)
  );

  // Slave address decode per channel. Out-of-range or non-byte accesses are
  // still acknowledged but never touch the arrays.
  logic [CHANNELS-1:0] ch_valid, ch_in_a, ch_hi;
  logic [IDX_W-1:0]    ch_idx   [CHANNELS];
  logic [DATA_W-1:0]   ch_rbyte [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0] addr8;
    logic [4:0] off_a, off_b;
    logic       in_a, in_b;
    elem_t      elem;

    assign addr8       = {1'b0, S_addr_ram[ADDR_W*c +: ADDR_W]};
    assign off_a       = 5'(addr8 - A_BASE);
    assign off_b       = 5'(addr8 - B_BASE);
    assign in_a        = (addr8 >= A_BASE) && (addr8 < A_BASE + SPAN);
    assign in_b        = (addr8 >= B_BASE) && (addr8 < B_BASE + SPAN);
    assign ch_valid[c] = (S_data_ram_size[SIZE_W*c +: SIZE_W] == 4'd8) &&
                         (in_a || in_b);
    assign ch_in_a[c]  = in_a;
    assign ch_idx[c]   = in_a ? off_a[4:1] : off_b[4:1];
    assign ch_hi[c]    = in_a ? off_a[0] : off_b[0];
    assign elem        = in_a ? mem_a[ch_idx[c]] : mem_b[ch_idx[c]];
    assign ch_rbyte[c] = ch_hi[c] ? elem[15:8] : elem[7:0];
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a start is only seen from IDLE, DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_port) next_state = SORT;
      SORT:    if (sort_last)  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Arrays, merge counters and slave responses. done_port is registered off
  // the DONE state so it rises one cycle after the last merged write.
  // Channels are walked in ascending order so channel 1 wins a write clash.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mem_a[i] <= INIT_TABLE[i];
        mem_b[i] <= '0;
      end
      pass           <= '0;
      blk_base       <= '0;
      li             <= '0;
      ri             <= '0;
      done_port      <= 1'b0;
      Sout_Rdata_ram <= '0;
      Sout_DataRdy   <= '0;
    end else begin
      done_port      <= (state == DONE);
      Sout_Rdata_ram <= '0;
      Sout_DataRdy   <= '0;
      case (state)
        IDLE: begin
          pass     <= '0;
          blk_base <= '0;
          li       <= '0;
          ri       <= '0;
          for (int c = 0; c < CHANNELS; c++) begin
            if (S_we_ram[c] || S_oe_ram[c]) begin
              Sout_DataRdy[c] <= 1'b1;
            end
            if (S_we_ram[c]) begin
              if (ch_valid[c]) begin
                if (ch_in_a[c]) begin
                  if (ch_hi[c]) mem_a[ch_idx[c]][15:8] <= S_Wdata_ram[DATA_W*c +: DATA_W];
                  else          mem_a[ch_idx[c]][7:0]  <= S_Wdata_ram[DATA_W*c +: DATA_W];
                end else begin
                  if (ch_hi[c]) mem_b[ch_idx[c]][15:8] <= S_Wdata_ram[DATA_W*c +: DATA_W];
                  else          mem_b[ch_idx[c]][7:0]  <= S_Wdata_ram[DATA_W*c +: DATA_W];
                end
              end
            end else if (S_oe_ram[c] && ch_valid[c]) begin
              Sout_Rdata_ram[DATA_W*c +: DATA_W] <= ch_rbyte[c];
            end
          end
        end
        SORT: begin
          if (pass[0]) mem_a[out_idx] <= sel;
          else         mem_b[out_idx] <= sel;
          if (blk_last) begin
            li       <= '0;
            ri       <= '0;
            blk_base <= out_idx + 4'd1;
            if (out_idx == 4'(N - 1)) pass <= pass + 2'd1;
          end else if (take_left) begin
            li <= li + 4'd1;
          end else begin
            ri <= ri + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mergesort_accel.sv
// tb_mergesort_accel
//  Directed bench for mergesort_accel. A reference array is kept in the bench
//  and sorted with a plain insertion sort whenever a start is accepted; a
//  per-cycle monitor predicts when done_port must pulse from start timing.
//  Honours MERGESORT_DESC_EN the same way as the design.
module tb_mergesort_accel;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_port = 1'b0;
  logic [1:0]  S_oe_ram = '0;
  logic [1:0]  S_we_ram = '0;
  logic [13:0] S_addr_ram = '0;
  logic [15:0] S_Wdata_ram = '0;
  logic [7:0]  S_data_ram_size = '0;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_done = -1;
  int next_ok = 0;

  int model_a [16];
  int dut_a [16];
  int init_vals [16] = '{11, -3, 7, 0, 250, -128, 42, 5, 5, -1, 99, 13, -77, 8, 1000, 2};
`ifdef MERGESORT_DESC_EN
  int sorted_lit [16] = '{1000, 250, 99, 42, 13, 11, 8, 7, 5, 5, 2, 0, -1, -3, -77, -128};
  int t2_lo_lit = 8'h0F;
  int t2_hi_lit = 8'h00;
`else
  int sorted_lit [16] = '{-128, -77, -3, -1, 0, 2, 5, 5, 7, 8, 11, 13, 42, 99, 250, 1000};
  int t2_lo_lit = 8'h00;
  int t2_hi_lit = 8'h0F;
`endif

  always #5 clock = ~clock;

  mergesort_accel dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reload();
    for (int i = 0; i < 16; i++) model_a[i] = init_vals[i];
  endfunction

  function automatic bit out_of_order(input int a, input int b);
`ifdef MERGESORT_DESC_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  function automatic void model_sort();
    for (int i = 1; i < 16; i++) begin
      int key = model_a[i];
      int j = i - 1;
      while (j >= 0 && out_of_order(model_a[j], key)) begin
        model_a[j + 1] = model_a[j];
        j--;
      end
      model_a[j + 1] = key;
    end
  endfunction

  function automatic void model_write(input int addr, input int data);
    logic [15:0] v;
    int idx;
    if (addr >= 64 && addr < 96) begin
      idx = (addr - 64) / 2;
      v = 16'(model_a[idx]);
      if (addr % 2 == 1) v[15:8] = 8'(data);
      else               v[7:0]  = 8'(data);
      model_a[idx] = int'($signed(v));
    end
  endfunction

  // Reference timing and contents: a start is accepted only once the previous
  // run's done cycle has passed; the sorted result is known at acceptance.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      exp_done = -1;
      next_ok  = 0;
      model_reload();
    end else if (start_port && cyc >= next_ok) begin
      exp_done = cyc + 65;
      next_ok  = cyc + 66;
      model_sort();
    end
  end

  // Compare process: done_port must pulse exactly on the predicted cycle.
  always @(negedge clock) begin
    check_output("done_pulse", int'(done_port), (reset && cyc == exp_done) ? 1 : 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // One slave cycle on both channels; enables are dropped after the edge.
  task automatic apply_stimulus(input logic [1:0] oe, input logic [1:0] we,
                                input int a0, input int a1, input int w0, input int w1,
                                input int s0, input int s1);
    S_oe_ram        = oe;
    S_we_ram        = we;
    S_addr_ram      = {7'(a1), 7'(a0)};
    S_Wdata_ram     = {8'(w1), 8'(w0)};
    S_data_ram_size = {4'(s1), 4'(s0)};
    tick();
    S_oe_ram = '0;
    S_we_ram = '0;
    if (we[0] && s0 == 8) model_write(a0, w0);
    if (we[1] && s1 == 8) model_write(a1, w1);
  endtask

  task automatic read_byte(input int ch, input int a, input int sz,
                           output int d, output int ack);
    if (ch == 0) apply_stimulus(2'b01, 2'b00, a, 0, 0, 0, sz, 8);
    else         apply_stimulus(2'b10, 2'b00, 0, a, 0, 0, 8, sz);
    d   = int'(Sout_Rdata_ram[8*ch +: 8]);
    ack = int'(Sout_DataRdy[ch]);
  endtask

  task automatic write_byte(input int ch, input int a, input int d);
    if (ch == 0) apply_stimulus(2'b00, 2'b01, a, 0, d, 0, 8, 8);
    else         apply_stimulus(2'b00, 2'b10, 0, a, 0, d, 8, 8);
    check_output("write_ack", int'(Sout_DataRdy[ch]), 1);
  endtask

  task automatic read_a(input string tag);
    int lo, hi, ack;
    for (int i = 0; i < 16; i++) begin
      read_byte(0, 64 + 2*i, 8, lo, ack);
      check_output("read_ack_lo", ack, 1);
      read_byte(1, 65 + 2*i, 8, hi, ack);
      check_output("read_ack_hi", ack, 1);
      dut_a[i] = int'($signed({8'(hi), 8'(lo)}));
      check_output(tag, dut_a[i], model_a[i]);
    end
  endtask

  task automatic run_sort(output int lat);
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    lat = 0;
    while (!done_port && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, d, ack, npulse, seen;
    int pulse_at [3];

    // Reset values
    tick(3);
    check_output("rst_done", int'(done_port), 0);
    check_output("rst_rdata", int'(Sout_Rdata_ram), 0);
    check_output("rst_rdy", int'(Sout_DataRdy), 0);
    reset = 1'b1;
    tick(2);

    // Sort the reset table
    run_sort(lat);
    check_output("t1_latency", lat, 65);
    for (int i = 0; i < 16; i++) check_output("t1_model_pin", model_a[i], sorted_lit[i]);
    read_a("t1_sorted");
    check_output("t1_first_lit", dut_a[0], sorted_lit[0]);
    check_output("t1_last_lit", dut_a[15], sorted_lit[15]);

    // Load 15..0 through the slave port and sort
    for (int i = 0; i < 16; i++) begin
      write_byte(0, 64 + 2*i, 15 - i);
      write_byte(1, 65 + 2*i, 0);
    end
    run_sort(lat);
    check_output("t2_latency", lat, 65);
    read_a("t2_sorted");
    read_byte(0, 64, 8, d, ack);
    check_output("t2_ch0_addr64", d, t2_lo_lit);
    read_byte(1, 94, 8, d, ack);
    check_output("t2_ch1_addr94", d, t2_hi_lit);

    // Start held high: one pulse per run, restarts only from IDLE
    npulse = 0;
    start_port = 1'b1;
    for (int k = 0; k <= 210; k++) begin
      tick();
      if (k == 139) start_port = 1'b0;
      if (done_port) begin
        if (npulse < 3) pulse_at[npulse] = k;
        npulse++;
      end
    end
    check_output("t3_pulses", npulse, 3);
    check_output("t3_pulse0", pulse_at[0], 65);
    check_output("t3_pulse1", pulse_at[1], 131);
    check_output("t3_pulse2", pulse_at[2], 197);

    // Reset in the middle of a sort
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    tick(30);
    reset = 1'b0;
    tick(2);
    check_output("t4_rst_done", int'(done_port), 0);
    check_output("t4_rst_rdy", int'(Sout_DataRdy), 0);
    reset = 1'b1;
    npulse = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done_port) npulse++;
    end
    check_output("t4_no_done", npulse, 0);
    read_a("t4_reloaded");
    for (int i = 0; i < 16; i++) check_output("t4_init_lit", dut_a[i], init_vals[i]);

    // Channel clash, unsupported size, out of range, oe+we together
    apply_stimulus(2'b00, 2'b11, 64, 64, 8'h11, 8'h22, 8, 8);
    check_output("t5_clash_ack", int'(Sout_DataRdy), 3);
    read_byte(0, 64, 8, d, ack);
    check_output("t5_clash_data", d, 8'h22);
    read_byte(1, 64, 16, d, ack);
    check_output("t5_size16_ack", ack, 1);
    check_output("t5_size16_data", d, 0);
    read_byte(0, 10, 8, d, ack);
    check_output("t5_oor_ack", ack, 1);
    check_output("t5_oor_data", d, 0);
    apply_stimulus(2'b00, 2'b01, 65, 0, 8'h55, 0, 16, 8);
    check_output("t5_drop_ack", int'(Sout_DataRdy[0]), 1);
    read_byte(0, 65, 8, d, ack);
    check_output("t5_drop_data", d, 8'h00);
    apply_stimulus(2'b01, 2'b01, 66, 0, 8'h33, 0, 8, 8);
    check_output("t5_oewe_ack", int'(Sout_DataRdy[0]), 1);
    read_byte(1, 66, 8, d, ack);
    check_output("t5_oewe_data", d, 8'h33);

    // Restart on current contents; slave ignored while sorting
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    tick(5);
    read_byte(0, 64, 8, d, ack);
    check_output("t6_busy_noack", ack, 0);
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      tick();
      if (done_port) seen = 1;
    end
    check_output("t6_done_seen", seen, 1);
    read_a("t6_sorted");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
